// File: rtl/icache_rxdat_beat_assembler.sv
// icache_rxdat_beat_assembler
//
// Collects the narrow data beats of one linefill response into a full cacheline.
// It then presents the line, together with its MSHR entry index, txnid and opcode,
// as a single valid/ready transfer to the icache data array controller.
// There is a single line buffer, so beats of different transactions never interleave.
//
// Optional feature macro: ICACHE_RXDAT_OOO_BEAT_EN
//   defined   : beats may arrive in any beat_id order. A per-slot mask tracks which
//               slots have been received. The line completes when the mask is full.
//               A repeated slot is flagged as an error and is overwritten.
//   undefined : beat_id must match the running beat count. A mismatch is flagged,
//               and the beat is written to the slot given by the count.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_bus_rxdat_*           narrow beat channel (vld/rdy, data, beat_id, last, entry_idx,
//                           txnid, opcode); o_bus_rxdat_rdy depends on state only
//   o_line_*, i_line_rdy    assembled line channel (vld/rdy, data, entry_idx, txnid, opcode)
//   o_err                   sticky protocol error, cleared only by reset
module icache_rxdat_beat_assembler #(
  parameter int unsigned BEAT_WIDTH      = 128,
  parameter int unsigned LINE_WIDTH      = 512,
  parameter int unsigned BEATS           = LINE_WIDTH / BEAT_WIDTH,
  parameter int unsigned ENTRY_IDX_WIDTH = 4,
  parameter int unsigned TXNID_WIDTH     = 8,
  parameter int unsigned OPCODE_WIDTH    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_bus_rxdat_vld,
  output logic                       o_bus_rxdat_rdy,
  input  logic [BEAT_WIDTH-1:0]      i_bus_rxdat_data,
  input  logic [$clog2(BEATS)-1:0]   i_bus_rxdat_beat_id,
  input  logic                       i_bus_rxdat_last,
  input  logic [ENTRY_IDX_WIDTH-1:0] i_bus_rxdat_entry_idx,
  input  logic [TXNID_WIDTH-1:0]     i_bus_rxdat_txnid,
  input  logic [OPCODE_WIDTH-1:0]    i_bus_rxdat_opcode,
  output logic                       o_line_vld,
  input  logic                       i_line_rdy,
  output logic [LINE_WIDTH-1:0]      o_line_data,
  output logic [ENTRY_IDX_WIDTH-1:0] o_line_entry_idx,
  output logic [TXNID_WIDTH-1:0]     o_line_txnid,
  output logic [OPCODE_WIDTH-1:0]    o_line_opcode,
  output logic                       o_err
);

  localparam int unsigned BidW = $clog2(BEATS);
  localparam int unsigned CntW = BidW + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e                             r_state, w_state_nxt;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]   r_line;
  logic [CntW-1:0]                    r_cnt;
  logic [ENTRY_IDX_WIDTH-1:0]         r_entry_idx;
  logic [TXNID_WIDTH-1:0]             r_txnid;
  logic [OPCODE_WIDTH-1:0]            r_opcode;
  logic                               r_err;

  logic                               w_beat_fire;
  logic                               w_line_fire;
  logic                               w_first;
  logic [BidW-1:0]                    w_slot;
  logic                               w_complete;
  logic                               w_id_err;
  logic                               w_meta_err;
  logic                               w_last_err;

  // Ready is a pure function of state; no path from either valid or i_line_rdy.
  assign o_bus_rxdat_rdy = (r_state != StHold);
  assign o_line_vld      = (r_state == StHold);
  assign w_beat_fire     = i_bus_rxdat_vld & o_bus_rxdat_rdy;
  assign w_line_fire     = o_line_vld & i_line_rdy;
  assign w_first         = (r_state == StIdle);

`ifdef ICACHE_RXDAT_OOO_BEAT_EN
  logic [BEATS-1:0] r_mask;
  logic [BEATS-1:0] w_beat_bit;
  logic [BEATS-1:0] w_mask_nxt;

  assign w_beat_bit = {{(BEATS-1){1'b0}}, 1'b1} << i_bus_rxdat_beat_id;
  assign w_mask_nxt = r_mask | w_beat_bit;
  assign w_slot     = i_bus_rxdat_beat_id;
  assign w_complete = &w_mask_nxt;
  // A slot already present in the mask is a duplicate.
  assign w_id_err   = |(r_mask & w_beat_bit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask <= '0;
    end else if (w_line_fire) begin
      r_mask <= '0;
    end else if (w_beat_fire) begin
      r_mask <= w_mask_nxt;
    end
  end
`else
  // In-order: the running count, not beat_id, selects the slot.
  assign w_slot     = r_cnt[BidW-1:0];
  assign w_complete = (r_cnt == CntW'(BEATS - 1));
  assign w_id_err   = (i_bus_rxdat_beat_id != w_slot);
`endif

  // The first beat defines the captured identity, so it cannot mismatch.
  assign w_meta_err = ~w_first &
                      ((i_bus_rxdat_entry_idx != r_entry_idx) |
                       (i_bus_rxdat_txnid != r_txnid));
  assign w_last_err = (i_bus_rxdat_last != w_complete);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_beat_fire) w_state_nxt = w_complete ? StHold : StCollect;
      end
      StCollect: begin
        if (w_beat_fire && w_complete) w_state_nxt = StHold;
      end
      StHold: begin
        if (i_line_rdy) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_line      <= '0;
      r_cnt       <= '0;
      r_entry_idx <= '0;
      r_txnid     <= '0;
      r_opcode    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_beat_fire) begin
        // Errors are informational: the beat is always written and the FSM advances.
        r_line[w_slot] <= i_bus_rxdat_data;
        r_cnt          <= r_cnt + 1'b1;
        r_err          <= r_err | w_id_err | w_meta_err | w_last_err;
        if (w_first) begin
          r_entry_idx <= i_bus_rxdat_entry_idx;
          r_txnid     <= i_bus_rxdat_txnid;
          r_opcode    <= i_bus_rxdat_opcode;
        end
      end
      if (w_line_fire) begin
        r_cnt <= '0;
      end
    end
  end

  assign o_line_data      = r_line;
  assign o_line_entry_idx = r_entry_idx;
  assign o_line_txnid     = r_txnid;
  assign o_line_opcode    = r_opcode;
  assign o_err            = r_err;

endmodule

// File: tb/tb_icache_rxdat_beat_assembler.sv
// Self-checking bench for icache_rxdat_beat_assembler. A behavioural model tracks
// which slots of the current line hold which data and applies the error rules.
// Directed scenarios are mixed with randomised clean lines.
module tb_icache_rxdat_beat_assembler;

  localparam int BW = 128;
  localparam int LW = 512;
  localparam int NB = 4;
  localparam int EW = 4;
  localparam int TW = 8;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic          rdy;
  logic [BW-1:0] data;
  logic [1:0]    bid;
  logic          last;
  logic [EW-1:0] ent;
  logic [TW-1:0] txn;
  logic [OW-1:0] op;
  logic          line_vld;
  logic          line_rdy;
  logic [LW-1:0] line_data;
  logic [EW-1:0] line_ent;
  logic [TW-1:0] line_txn;
  logic [OW-1:0] line_op;
  logic          err;

  always #5 clk = ~clk;

  icache_rxdat_beat_assembler #(
    .BEAT_WIDTH      (BW),
    .LINE_WIDTH      (LW),
    .BEATS           (NB),
    .ENTRY_IDX_WIDTH (EW),
    .TXNID_WIDTH     (TW),
    .OPCODE_WIDTH    (OW)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_bus_rxdat_vld       (vld),
    .o_bus_rxdat_rdy       (rdy),
    .i_bus_rxdat_data      (data),
    .i_bus_rxdat_beat_id   (bid),
    .i_bus_rxdat_last      (last),
    .i_bus_rxdat_entry_idx (ent),
    .i_bus_rxdat_txnid     (txn),
    .i_bus_rxdat_opcode    (op),
    .o_line_vld            (line_vld),
    .i_line_rdy            (line_rdy),
    .o_line_data           (line_data),
    .o_line_entry_idx      (line_ent),
    .o_line_txnid          (line_txn),
    .o_line_opcode         (line_op),
    .o_err                 (err)
  );

  int n_asrt;
  int n_fail;

  // Beat stimulus table for the current transaction.
  logic [BW-1:0] b_data [8];
  int            b_id   [8];
  bit            b_last [8];
  logic [EW-1:0] b_ent  [8];
  logic [TW-1:0] b_txn  [8];
  logic [OW-1:0] b_op   [8];
  int            n_beats;

  // Reference model state.
  logic [BW-1:0] m_slot [NB];
  int            m_cnt;
  logic [EW-1:0] m_ent;
  logic [TW-1:0] m_txn;
  logic [OW-1:0] m_op;
  bit            m_err;
`ifdef ICACHE_RXDAT_OOO_BEAT_EN
  bit            m_seen [NB];
`endif

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_line();
    logic [LW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*BW +: BW] = m_slot[i];
    return r;
  endfunction

  // Applies the line-assembly rules to beat k of the table; reports line completion.
  task automatic model_beat(input int k, output bit complete);
    int slot;
    if (m_cnt == 0) begin
      m_ent = b_ent[k];
      m_txn = b_txn[k];
      m_op  = b_op[k];
`ifdef ICACHE_RXDAT_OOO_BEAT_EN
      for (int i = 0; i < NB; i++) m_seen[i] = 1'b0;
`endif
    end else if (b_ent[k] != m_ent || b_txn[k] != m_txn) begin
      m_err = 1'b1;
    end
`ifdef ICACHE_RXDAT_OOO_BEAT_EN
    slot = b_id[k];
    if (m_seen[slot]) m_err = 1'b1;
    m_seen[slot] = 1'b1;
    complete = 1'b1;
    for (int i = 0; i < NB; i++) if (!m_seen[i]) complete = 1'b0;
`else
    slot = m_cnt;
    if (b_id[k] != m_cnt) m_err = 1'b1;
    complete = (m_cnt == NB - 1);
`endif
    m_slot[slot] = b_data[k];
    m_cnt++;
    if (b_last[k] != complete) m_err = 1'b1;
  endtask

  task automatic after_accept(input int k);
    bit c;
    model_beat(k, c);
    check("err_after_beat", err, m_err);
    if (c) begin
      check("line_vld_on_complete", line_vld, 1'b1);
      check("rdy_in_hold", rdy, 1'b0);
      check("line_data", line_data, exp_line());
      check("line_entry_idx", line_ent, m_ent);
      check("line_txnid", line_txn, m_txn);
      check("line_opcode", line_op, m_op);
    end else begin
      check("line_vld_mid_line", line_vld, 1'b0);
      check("rdy_mid_line", rdy, 1'b1);
    end
  endtask

  task automatic drive_beat(input int k);
    data = b_data[k];
    bid  = 2'(b_id[k]);
    last = b_last[k];
    ent  = b_ent[k];
    txn  = b_txn[k];
    op   = b_op[k];
    vld  = 1'b1;
  endtask

  // Called #1 after a rising edge; leaves time #1 after the accepting edge.
  task automatic send_beat(input int k, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    drive_beat(k);
    t = 0;
    while (rdy !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 50) check("rdy_timeout", rdy, 1'b1);
    @(posedge clk);
    #1;
    vld = 1'b0;
    after_accept(k);
  endtask

  task automatic send_line(input int from, input int max_gap);
    for (int k = from; k < n_beats; k++) send_beat(k, $urandom_range(0, max_gap));
  endtask

  task automatic handoff(input int hold);
    logic [LW-1:0] held;
    held = exp_line();
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_line_vld", line_vld, 1'b1);
      check("hold_rdy", rdy, 1'b0);
      check("hold_line_data", line_data, held);
    end
    line_rdy = 1'b1;
    @(posedge clk);
    #1;
    line_rdy = 1'b0;
    m_cnt = 0;
    check("handoff_line_vld", line_vld, 1'b0);
    check("handoff_rdy", rdy, 1'b1);
    check("handoff_err", err, m_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    check("rst_line_vld", line_vld, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdy", rdy, 1'b1);
    check("rst_line_data", line_data, '0);
    check("rst_line_meta", {line_ent, line_txn, line_op}, '0);
  endtask

  task automatic load_directed(input logic [7:0] base);
    for (int k = 0; k < NB; k++) begin
      b_data[k] = {16{base + 8'(k * 8'h11)}};
      b_id[k]   = k;
      b_last[k] = (k == NB - 1);
      b_ent[k]  = 4'd3;
      b_txn[k]  = 8'h15;
      b_op[k]   = 2'd1;
    end
    n_beats = NB;
  endtask

  task automatic load_random();
    logic [EW-1:0] e;
    logic [TW-1:0] t;
    logic [OW-1:0] o;
    e = EW'($urandom);
    t = TW'($urandom);
    o = OW'($urandom);
    for (int k = 0; k < NB; k++) begin
      b_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_id[k]   = k;
      b_last[k] = (k == NB - 1);
      b_ent[k]  = e;
      b_txn[k]  = t;
      b_op[k]   = o;
    end
`ifdef ICACHE_RXDAT_OOO_BEAT_EN
    for (int k = NB - 1; k > 0; k--) begin
      int j;
      int tmp;
      j = $urandom_range(0, k);
      tmp = b_id[k];
      b_id[k] = b_id[j];
      b_id[j] = tmp;
    end
`endif
    n_beats = NB;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    rst = 1'b1;
    vld = 1'b0;
    data = '0;
    bid = '0;
    last = 1'b0;
    ent = '0;
    txn = '0;
    op = '0;
    line_rdy = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // In-order directed line: 0x11.., 0x22.., 0x33.., 0x44.., entry 3, txnid 0x15.
    load_directed(8'h11);
    send_line(0, 0);
    check("inorder_line_data", line_data,
          {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}});
    check("inorder_entry", line_ent, 4'd3);
    check("inorder_txnid", line_txn, 8'h15);
    check("inorder_err", err, 1'b0);
    handoff(2);

    // Back-pressure: next first beat offered while the line is held for 5 cycles.
    load_directed(8'h11);
    send_line(0, 0);
    load_directed(8'h51);
    b_txn[0] = 8'h16; b_txn[1] = 8'h16; b_txn[2] = 8'h16; b_txn[3] = 8'h16;
    drive_beat(0);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_rdy", rdy, 1'b0);
      check("bp_line_vld", line_vld, 1'b1);
      check("bp_line_data", line_data, exp_line());
      check("bp_line_txnid", line_txn, 8'h15);
    end
    line_rdy = 1'b1;
    @(posedge clk);
    #1;
    line_rdy = 1'b0;
    m_cnt = 0;
    check("bp_vld_drop", line_vld, 1'b0);
    check("bp_rdy_idle", rdy, 1'b1);
    @(posedge clk);
    #1;
    vld = 1'b0;
    after_accept(0);
    send_line(1, 1);
    check("bp_new_txnid", line_txn, 8'h16);
    handoff(0);

    // Randomised clean lines.
    for (int r = 0; r < 8; r++) begin
      load_random();
      send_line(0, 2);
      handoff($urandom_range(0, 3));
    end

    // Early last on beat 1: err rises, no line until beats 2 and 3; err survives handoff.
    do_reset();
    load_directed(8'h11);
    b_last[1] = 1'b1;
    send_line(0, 0);
    handoff(1);
    check("early_last_err_sticky", err, 1'b1);

    // Entry mismatch on beat 2: line still carries the captured entry 3.
    do_reset();
    load_directed(8'h11);
    b_ent[2] = 4'd5;
    send_line(0, 0);
    check("mismatch_entry_kept", line_ent, 4'd3);
    check("mismatch_err", err, 1'b1);
    handoff(0);

    // beat_id order 2,0,3,1.
    do_reset();
    load_directed(8'h11);
    b_id[0] = 2; b_id[1] = 0; b_id[2] = 3; b_id[3] = 1;
    send_line(0, 0);
`ifdef ICACHE_RXDAT_OOO_BEAT_EN
    check("ooo_err_clean", err, 1'b0);
`else
    check("inorder_id_err", err, 1'b1);
`endif
    handoff(0);

`ifdef ICACHE_RXDAT_OOO_BEAT_EN
    // Duplicate beat_id 0 mid-line: flagged, overwritten, line completes on the 5th beat.
    do_reset();
    load_directed(8'h11);
    n_beats = 5;
    b_id[0] = 0; b_id[1] = 2; b_id[2] = 0; b_id[3] = 1; b_id[4] = 3;
    b_data[4] = {16{8'h99}};
    b_last[3] = 1'b0; b_last[4] = 1'b1;
    b_ent[4] = 4'd3; b_txn[4] = 8'h15; b_op[4] = 2'd1;
    send_line(0, 0);
    check("dup_err", err, 1'b1);
    handoff(0);
`endif

    // Reset in COLLECT after two beats, then a fresh line.
    do_reset();
    load_directed(8'h11);
    send_beat(0, 0);
    send_beat(1, 0);
    do_reset();
    load_directed(8'h5a);
    send_line(0, 0);
    check("fresh_err", err, 1'b0);
    handoff(0);

    for (int r = 0; r < 4; r++) begin
      load_random();
      send_line(0, 2);
      handoff($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
